// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the run sequencer: state encoding, default run length,
// and the zero-length substitution rule.
package seq_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int unsigned LEN_DEF_DFLT = 16;

  // A requested length of zero means "use the default length".
  function automatic int unsigned len_sub(input int unsigned l, input int unsigned d);
    return (l == 0) ? d : l;
  endfunction

endpackage

// File: rtl/seq_ctrl_gen.sv
// Run sequencer: a level request launches start -> RUN(count 0..len) -> done, with abort.
// Optional SEQ_CTRL_AUTORESTART_EN: DONE with s held goes straight to START.
module seq_ctrl_gen
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned LEN_DEF = LEN_DEF_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             start,
  output logic             str,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LEN_DEF_Q = CNT_W'(LEN_DEF);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_eff;

  assign len_eff = CNT_W'(len_sub(32'(len), LEN_DEF));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      len_q <= LEN_DEF_Q;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (s) begin
            state <= ST_START;
            len_q <= len_eff;
          end
        end
        ST_START: begin
          count <= '0;
          state <= abort ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          // abort takes priority over normal completion on the final count
          if (abort) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (count == len_q) begin
            state <= ST_DONE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          count <= '0;
`ifdef SEQ_CTRL_AUTORESTART_EN
          if (s) begin
            state <= ST_START;
            len_q <= len_eff;
          end else begin
            state <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
      endcase
    end
  end

  // len_q is never zero, so len_q-1 cannot underflow
  assign start = (state == ST_START);
  assign str   = (state == ST_RUN) && (count == len_q - 1'b1);
  assign done  = (state == ST_DONE);
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_seq_ctrl_gen.sv
// Self-checking bench for seq_ctrl_gen: expected per-cycle output traces are built
// from the run rules (start, count 0..L with strobe at L-1, done) and compared each cycle.
module tb_seq_ctrl_gen;

  localparam int CNT_W = 5;
  localparam int LDEF  = 16;

  typedef logic [CNT_W+3:0] obs_t;  // {start, str, done, busy, count}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic             start, str, done, busy;
  logic [CNT_W-1:0] count;
  obs_t             obs;

  int total = 0;
  int bad = 0;
  obs_t exp_q[$];

  seq_ctrl_gen #(.CNT_W(CNT_W), .LEN_DEF(LDEF)) dut (
    .clk(clk), .rst(rst), .s(s), .len(len), .abort(abort),
    .start(start), .str(str), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;
  assign obs = {start, str, done, busy, count};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int l);
    return (l == 0) ? LDEF : l;
  endfunction

  // Append the trace of one run of effective length l; if k>=0 the run is aborted
  // while item k is showing, so the trace stops at item k.
  function automatic void build(input int l, input int k);
    obs_t o;
    for (int i = 0; i <= l + 2; i++) begin
      if (i == 0)          o = {4'b1001, CNT_W'(0)};
      else if (i <= l + 1) o = {1'b0, ((i - 1) == (l - 1)), 2'b01, CNT_W'(i - 1)};
      else                 o = {4'b0011, CNT_W'(0)};
      exp_q.push_back(o);
      if (i == k) break;
    end
  endfunction

  task automatic test_reset();
    tick();
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_c1 got=%h want=0", obs); end
    s = 1'b1; abort = 1'b1; len = 5'd3;
    tick();
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_c2 got=%h want=0", obs); end
    rst = 1'b0; s = 1'b0; abort = 1'b0;
    tick();
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_idle got=%h want=0", obs); end
  endtask

  task automatic test_basic();
    exp_q.delete();
    build(16, -1);
    exp_q.push_back('0);
    s = 1'b1; len = 5'd16;
    tick();
    s = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL basic item=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_len_edge();
    int lv[2] = '{0, 1};
    for (int n = 0; n < 2; n++) begin
      exp_q.delete();
      build(eff(lv[n]), -1);
      exp_q.push_back('0);
      s = 1'b1; len = CNT_W'(lv[n]);
      tick();
      s = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs !== exp_q[i]) begin
          bad++; $display("FAIL len_edge len=%0d item=%0d got=%h want=%h", lv[n], i, obs, exp_q[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_abort(input int l, input int k);
    exp_q.delete();
    build(l, k);
    exp_q.push_back('0);
    s = 1'b1; len = CNT_W'(l);
    tick();
    s = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL abort len=%0d k=%0d item=%0d got=%h want=%h", l, k, i, obs, exp_q[i]);
      end
      abort = (i == k);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    int last;
    exp_q.delete();
    build(4, -1);
`ifndef SEQ_CTRL_AUTORESTART_EN
    exp_q.push_back('0);
`endif
    build(4, -1);
    exp_q.push_back('0);
    last = exp_q.size() - 1;
    s = 1'b1; len = 5'd4;
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL back_to_back item=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
      if (i == last - 1) s = 1'b0;
      tick();
    end
  endtask

  task automatic test_len_change();
    exp_q.delete();
    build(3, -1);
    exp_q.push_back('0);
    s = 1'b1; len = 5'd3;
    tick();
    s = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL len_change_a item=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
      if (i == 1) len = 5'd9;
      tick();
    end
    exp_q.delete();
    build(9, -1);
    exp_q.push_back('0);
    s = 1'b1;
    tick();
    s = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL len_change_b item=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    build(10, 6);
    s = 1'b1; len = 5'd10;
    tick();
    s = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL reset_mid item=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
      tick();
      if (i == exp_q.size() - 2) rst = 1'b1;
    end
    // the last loop tick applied rst while count 5 was showing
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_mid_out got=%h want=0", obs); end
    rst = 1'b0;
    tick();
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_mid_idle got=%h want=0", obs); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      int lv, l, k, last;
      lv = $urandom_range(0, 31);
      l = eff(lv);
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, l + 1)) : -1;
      exp_q.delete();
      build(l, k);
      exp_q.push_back('0);
      last = exp_q.size() - 1;
      s = 1'b1; len = CNT_W'(lv);
      tick();
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs !== exp_q[i]) begin
          bad++; $display("FAIL random run=%0d len=%0d k=%0d item=%0d got=%h want=%h",
                          r, lv, k, i, obs, exp_q[i]);
        end
        len = CNT_W'($urandom_range(0, 31));
        if (i == last) begin
          s = 1'b0; abort = 1'b0;
        end else if (k < 0 && i == l + 2) begin
          s = 1'b0; abort = 1'($urandom_range(0, 1));
        end else begin
          s = 1'($urandom_range(0, 1)); abort = (i == k);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_edge();
    test_abort(10, 8);
    test_abort(5, 6);
    test_abort(7, 0);
    test_back_to_back();
    test_len_change();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
